// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage word port onto a 16-bit async SRAM
// Each word moves as two halfword accesses (low half first), each held WAIT_CYCLES clocks.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 4,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_e;

  localparam int              CW       = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [31:0]     BASE     = 32'(BASE_ADDR);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               we_n_q, we_n_d;
  logic [15:0]        dq_q, dq_d;
  logic [31:0]        off;
  logic               last;
  logic               unused_off;

  assign off        = address - BASE;
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
  assign last       = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      dq_q    <= dq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (wr_en || rd_en) begin
          word_d  = off[SRAM_AW:2];
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = wr_en ? WR_LO : RD_LO;
        end
      end
      RD_LO, RD_HI, WR_LO, WR_HI: begin
        if (last) begin
          cnt_d = '0;
          case (state_q)
            RD_LO:   state_d = RD_HI;
            WR_LO:   state_d = WR_HI;
            default: state_d = DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered from the state being entered, so they change with it.
  always_comb begin
    addr_d  = addr_q;
    we_n_d  = 1'b1;
    dq_d    = dq_q;
    rdata_d = rdata_q;
    ready   = 1'b0;
    case (state_d)
      RD_LO:   addr_d = {word_d, 1'b0};
      RD_HI:   addr_d = {word_d, 1'b1};
      WR_LO: begin
        addr_d = {word_d, 1'b0};
        we_n_d = 1'b0;
        dq_d   = wdata_d[15:0];
      end
      WR_HI: begin
        addr_d = {word_d, 1'b1};
        we_n_d = 1'b0;
        dq_d   = wdata_d[31:16];
      end
      default: ;
    endcase
    if (state_q == RD_LO && last) rdata_d[15:0]  = SRAM_DQ;
    if (state_q == RD_HI && last) rdata_d[31:16] = SRAM_DQ;
    if (state_q == IDLE)      ready = ~(rd_en | wr_en);
    else if (state_q == DONE) ready = 1'b1;
  end

  assign SRAM_DQ   = we_n_q ? 16'bz : dq_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed and random word traffic against an SRAM model and word-level reference
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  tri1  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: drives reads whenever WE_N is high, samples writes at posedge.
  logic [15:0] mem [0:(1<<18)-1];
  bit          model_en;
  assign sram_dq = (sram_we_n && model_en) ? mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

  int checks;
  int failures;
  logic [31:0] ref_mem [int];
  int          written [$];
  logic [17:0] wr_addrs [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  // Issue one request and hold it until ready; return stall count and what was seen on the bus.
  task automatic txn(input bit is_wr, input logic [31:0] a, input logic [31:0] d, input bit hold,
                     output int lowcnt, output logic [31:0] rd, output bit we_seen, output bit dq_bad,
                     output bit tmo);
    address    = a;
    write_data = d;
    wr_en      = is_wr;
    rd_en      = !is_wr;
    lowcnt     = 0;
    we_seen    = 0;
    dq_bad     = 0;
    wr_addrs.delete();
    #1;
    for (int i = 0; i < 100; i++) begin
      if (ready) break;
      lowcnt++;
      if (!sram_we_n) begin
        we_seen = 1;
        if (wr_addrs.size() == 0 || wr_addrs[$] != sram_addr) wr_addrs.push_back(sram_addr);
        if (sram_dq !== (sram_addr[0] ? d[31:16] : d[15:0])) dq_bad = 1;
      end
      @(negedge clk);
      #1;
    end
    tmo = !ready;
    rd  = read_data;
    if (!hold) begin
      wr_en = 0;
      rd_en = 0;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    int lc; logic [31:0] rd; bit we, bad, tmo;
    txn(1, a, d, 0, lc, rd, we, bad, tmo);
    ref_mem[word_of(a)] = d;
    chk({tag, "_timeout"}, 32'(tmo), 0);
    chk({tag, "_stall"}, lc, 9);
    chk({tag, "_we"}, 32'(we), 1);
    chk({tag, "_dq"}, 32'(bad), 0);
    chk({tag, "_mem"}, {mem[18'(2*word_of(a)+1)], mem[18'(2*word_of(a))]}, d);
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    int lc; logic [31:0] rd; bit we, bad, tmo;
    txn(0, a, 32'h0, 0, lc, rd, we, bad, tmo);
    chk({tag, "_timeout"}, 32'(tmo), 0);
    chk({tag, "_stall"}, lc, 9);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_data"}, rd, ref_mem[word_of(a)]);
  endtask

  task automatic idle_gap(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_idle_ready"}, 32'(ready), 1);
  endtask

  initial begin
    int          lc;
    logic [31:0] rd, d;
    bit          we, bad, tmo;
    int          w;

    checks = 0; failures = 0;
    rst = 1; wr_en = 0; rd_en = 0; address = 0; write_data = 0; model_en = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_dq_released", 32'(sram_dq), 32'h0000_FFFF);
    chk("rst_read_data", read_data, 0);
    chk("rst_addr", 32'(sram_addr), 0);
    model_en = 1;

    @(negedge clk);
    do_write(32'd1024, 32'hDEADBEEF, "wr1024");
    chk("wr1024_lo", 32'(mem[0]), 32'h0000BEEF);
    chk("wr1024_hi", 32'(mem[1]), 32'h0000DEAD);
    idle_gap("wr1024");
    do_read(32'd1024, "rd1024");
    idle_gap("rd1024");

    do_write(32'd1032, 32'h12345678, "wr1032");
    chk("wr1032_naddr", wr_addrs.size(), 2);
    if (wr_addrs.size() == 2) begin
      chk("wr1032_addr_lo", 32'(wr_addrs[0]), 4);
      chk("wr1032_addr_hi", 32'(wr_addrs[1]), 5);
    end
    chk("wr1032_m4", 32'(mem[4]), 32'h00005678);
    chk("wr1032_m5", 32'(mem[5]), 32'h00001234);
    idle_gap("wr1032");
    do_read(32'd1032, "rd1032");
    idle_gap("rd1032");

    // Back-to-back: write held through DONE, read issued in the following IDLE cycle.
    d = $urandom;
    txn(1, 32'd1028, d, 1, lc, rd, we, bad, tmo);
    ref_mem[word_of(32'd1028)] = d;
    chk("b2b_wr_stall", lc, 9);
    @(negedge clk);
    txn(0, 32'd1028, 32'h0, 0, lc, rd, we, bad, tmo);
    chk("b2b_rd_timeout", 32'(tmo), 0);
    chk("b2b_rd_stall", lc, 9);
    chk("b2b_rd_data", rd, d);
    idle_gap("b2b");

    for (int k = 0; k < 8; k++) begin
      w = int'($urandom_range(0, 63));
      d = $urandom;
      written.push_back(w);
      do_write(32'd1024 + 32'(w * 4) + 32'($urandom_range(0, 3)), d, "rnd_wr");
      idle_gap("rnd_wr");
      w = written[$urandom_range(0, written.size() - 1)];
      do_read(32'd1024 + 32'(w * 4) + 32'($urandom_range(0, 3)), "rnd_rd");
      idle_gap("rnd_rd");
    end

    // Reset in the second RD_HI cycle of a read.
    chk("pre_rst_data_nonzero", 32'(read_data != 0), 1);
    address = 32'd1024; rd_en = 1;
    repeat (6) @(negedge clk);
    rst = 1; rd_en = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_read_data", read_data, 0);
    chk("abort_we_n", 32'(sram_we_n), 1);
    rd_en = 1;
    #1;
    chk("abort_ready_follows_req", 32'(ready), 0);
    rd_en = 0;
    @(negedge clk);
    do_read(32'd1032, "post_abort_rd");
    idle_gap("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
